hilo_mul_ctrl: RTL and testbench
================================

Name: hilo_mul_ctrl

Overview:
Sequencer and HI/LO register unit that sits between the EX stage and the shift-add multiplier. It accepts an unsigned MULTU request and drives the multiplier operands and enable for the required number of cycles. While the multiply runs it stalls the pipeline, then captures the 64-bit product into HI/LO. It also serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
MUL_CYCLES, 33, number of rising edges en_mul_o is held high before capture (multiplier iterations).
WARMUP, 3, cycles after reset release during which start is refused (multiplier ignores enable early after reset).

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  one-cycle MULTU request from EX
op_a_i  in  32  multiplicand (rs)
op_b_i  in  32  multiplier (rt)
mcnd_o  out  32  registered multiplicand to multiplier
mplr_o  out  32  registered multiplier operand to multiplier
en_mul_o  out  1  multiplier enable
product_i  in  64  product from multiplier
busy_o  out  1  pipeline stall request
done_o  out  1  one-cycle completion pulse
mfhi_i  in  1  read HI
mflo_i  in  1  read LO
mthi_i  in  1  write HI
mtlo_i  in  1  write LO
wdata_i  in  32  MTHI/MTLO data
rdata_o  out  32  MFHI/MFLO read data
hi_o  out  32  HI register
lo_o  out  32  LO register

Behaviour:
- Reset (async, any state): state=WARMUP, warm-up counter=0, iteration counter=0. Outputs: en_mul_o=0, busy_o=1, done_o=0, mcnd_o=mplr_o=0, HI=LO=0.
- States: WARMUP, IDLE, RUN, CAPTURE, DONE. All registered outputs change only on rising clk.
- WARMUP: busy_o=1. start_i is ignored, not queued. After WARMUP cycles the block moves to IDLE.
- IDLE/DONE: busy_o=0. When start_i=1 at an edge E0: mcnd_o<=op_a_i, mplr_o<=op_b_i, en_mul_o<=1, state<=RUN, counter<=0.
- RUN: en_mul_o=1, busy_o=1. The counter increments on each edge. On the edge where counter reaches MUL_CYCLES-1, state<=CAPTURE. en_mul_o is therefore high for edges E1..E(MUL_CYCLES).
- CAPTURE: en_mul_o stays 1, because the multiplier clears its product when enable falls. At edge E(MUL_CYCLES+1): HI<=product_i[63:32], LO<=product_i[31:0], en_mul_o<=0, done_o<=1, state<=DONE.
- DONE: one cycle long. en_mul_o=0, which guarantees at least one low cycle between multiplies. done_o=1 and busy_o=0. A start_i in DONE is accepted exactly as in IDLE. Without a start, the next state is IDLE and done_o returns to 0.
- Latency: start at E0 gives new HI/LO and done_o visible after E(MUL_CYCLES+1), i.e. 35 cycles for the default.
- mcnd_o/mplr_o hold their values until the next accepted start.
- Read path is combinational: mfhi_i gives HI; else mflo_i gives LO; else 0. If both are asserted, HI wins.
- Reads while busy return the old HI/LO. The pipeline is stalled by busy_o.
- MTHI/MTLO are applied at the edge when asserted in IDLE/DONE. They are ignored in WARMUP, RUN and CAPTURE.
- If mthi_i and start_i are both asserted in the same cycle: HI takes wdata_i now and is overwritten by the product at capture.
- If mthi_i and mtlo_i are both asserted, both registers take wdata_i.
- start_i while busy is ignored, with no queuing.
- A reset mid-multiply aborts immediately: en_mul_o=0, HI/LO=0, and the block re-enters WARMUP.
- Arithmetic is unsigned. The full 64-bit product is stored with no truncation.

Test Plan:
- Reset, pulse start_i on cycle 1 after release -> ignored, busy_o=1 for 3 cycles, en_mul_o stays 0, then busy_o=0.
- In IDLE, start with op_a=3, op_b=5 -> en_mul_o high exactly 34 cycles; done_o pulses 35 cycles after start; HI=0x00000000, LO=0x0000000F; mflo_i returns 0x0000000F.
- op_a=op_b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. mfhi_i and mflo_i asserted together -> rdata_o=0xFFFFFFFE.
- Back-to-back: start 0x10000×0x10000, then start in the DONE cycle with 7×6 -> first gives HI=0x00000001, LO=0; en_mul_o low for exactly 1 cycle between runs; second gives HI=0, LO=0x0000002A.
- mthi_i with wdata=0xDEADBEEF in IDLE -> HI=0xDEADBEEF next cycle. mtlo_i asserted during RUN -> LO unchanged.
- Assert rst at cycle 10 of RUN -> en_mul_o=0, HI/LO=0, busy_o=1 immediately. After 3 warm-up cycles, a fresh 2×2 gives LO=4.

Source files
------------

// File: rtl/hilo_mul_ctrl.sv
// HI/LO register unit and MULTU sequencer for the shift-add multiplier.
// Accepts a one-cycle start from EX, drives operands and enable to the
// multiplier while stalling the pipeline, then captures the 64-bit product
// into HI/LO. Also serves MFHI/MFLO reads and MTHI/MTLO writes.
module hilo_mul_ctrl #(
  parameter int MUL_CYCLES = 33,
  parameter int WARMUP     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] mcnd_o,
  output logic [31:0] mplr_o,
  output logic        en_mul_o,
  input  logic [63:0] product_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic        mfhi_i,
  input  logic        mflo_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CNT_W  = $clog2(MUL_CYCLES + 1);
  localparam int WCNT_W = $clog2(WARMUP + 1);
  localparam logic [CNT_W-1:0]  ITER_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP - 1);

  typedef enum logic [2:0] {
    S_WARMUP,
    S_IDLE,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  iter_cnt, iter_nxt;
  logic [WCNT_W-1:0] warm_cnt, warm_nxt;
  logic              en_nxt;
  logic              done_nxt;
  logic              load_ops;
  logic [31:0]       hi_nxt, lo_nxt;

  // State, counters and all registered outputs; reset aborts any multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_WARMUP;
      iter_cnt <= '0;
      warm_cnt <= '0;
      en_mul_o <= 1'b0;
      done_o   <= 1'b0;
      mcnd_o   <= '0;
      mplr_o   <= '0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_nxt;
      warm_cnt <= warm_nxt;
      en_mul_o <= en_nxt;
      done_o   <= done_nxt;
      hi_o     <= hi_nxt;
      lo_o     <= lo_nxt;
      if (load_ops) begin
        mcnd_o <= op_a_i;
        mplr_o <= op_b_i;
      end
    end
  end

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_cnt;
    warm_nxt  = warm_cnt;
    en_nxt    = en_mul_o;
    done_nxt  = 1'b0;
    load_ops  = 1'b0;
    hi_nxt    = hi_o;
    lo_nxt    = lo_o;
    case (state)
      S_WARMUP: begin
        // The multiplier ignores enable right after reset, so starts are
        // dropped (not queued) until the warm-up count expires.
        en_nxt = 1'b0;
        if (warm_cnt == WARM_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          warm_nxt = warm_cnt + 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        // Register writes land now; a simultaneous start will later
        // overwrite them with the product.
        if (mthi_i) hi_nxt = wdata_i;
        if (mtlo_i) lo_nxt = wdata_i;
        en_nxt = 1'b0;
        if (start_i) begin
          load_ops  = 1'b1;
          en_nxt    = 1'b1;
          iter_nxt  = '0;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        en_nxt = 1'b1;
        if (iter_cnt == ITER_LAST) begin
          state_nxt = S_CAPTURE;
        end else begin
          iter_nxt = iter_cnt + 1'b1;
        end
      end
      S_CAPTURE: begin
        // Enable drops only together with the capture: the multiplier
        // clears its product as soon as enable goes low.
        hi_nxt    = product_i[63:32];
        lo_nxt    = product_i[31:0];
        en_nxt    = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = S_DONE;
      end
      default: begin
        en_nxt    = 1'b0;
        state_nxt = S_WARMUP;
      end
    endcase
  end

  // Stall whenever a start could not be accepted this cycle.
  always_comb begin
    busy_o = (state == S_WARMUP) || (state == S_RUN) || (state == S_CAPTURE);
  end

  // Combinational read port; HI has priority when both reads are asserted.
  always_comb begin
    rdata_o = '0;
    if (mfhi_i) begin
      rdata_o = hi_o;
    end else if (mflo_i) begin
      rdata_o = lo_o;
    end
  end

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Self-checking bench for hilo_mul_ctrl: table of multiply vectors with
// hand-computed HI/LO, plus hand sequences for warm-up, MTHI/MTLO, back-to-back
// starts and reset in the middle of a multiply.
module tb_hilo_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic [31:0] mcnd_o;
  logic [31:0] mplr_o;
  logic        en_mul_o;
  logic [63:0] product_i;
  logic        busy_o;
  logic        done_o;
  logic        mfhi_i = 1'b0;
  logic        mflo_i = 1'b0;
  logic        mthi_i = 1'b0;
  logic        mtlo_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  hilo_mul_ctrl #(.MUL_CYCLES(33), .WARMUP(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_a_i    (op_a_i),
    .op_b_i    (op_b_i),
    .mcnd_o    (mcnd_o),
    .mplr_o    (mplr_o),
    .en_mul_o  (en_mul_o),
    .product_i (product_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .mfhi_i    (mfhi_i),
    .mflo_i    (mflo_i),
    .mthi_i    (mthi_i),
    .mtlo_i    (mtlo_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product is only valid after 33 enabled edges and
  // is cleared whenever enable is low.
  logic [7:0]  mcyc;
  logic [63:0] full_prod;
  always @(posedge clk or posedge rst) begin
    if (rst) mcyc <= 8'd0;
    else if (!en_mul_o) mcyc <= 8'd0;
    else if (mcyc != 8'hFF) mcyc <= mcyc + 8'd1;
  end
  assign full_prod = {32'd0, mcnd_o} * {32'd0, mplr_o};
  assign product_i = (mcyc >= 8'd33) ? full_prod : 64'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Issue a start and sample after each edge until done_o (bounded).
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output int en_cnt, output int done_k);
    op_a_i  = a;
    op_b_i  = b;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    en_cnt  = 0;
    done_k  = -1;
    for (int k = 0; k < 100; k++) begin
      if (en_mul_o) en_cnt++;
      if (done_o) begin
        done_k = k;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt;
    int done_k;
    logic [31:0] lo_before;

    vecs[0] = '{32'd3,         32'd5,         32'h00000000, 32'h0000000F};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{32'h00010000,  32'h00010000,  32'h00000001, 32'h00000000};
    vecs[3] = '{32'd7,         32'd6,         32'h00000000, 32'h0000002A};
    vecs[4] = '{32'h80000000,  32'd2,         32'h00000001, 32'h00000000};
    vecs[5] = '{32'h12345678,  32'h00000010,  32'h00000001, 32'h23456780};

    // Reset state
    step();
    step();
    chk("rst_en",   {63'd0, en_mul_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o},   64'd1);
    chk("rst_done", {63'd0, done_o},   64'd0);
    chk("rst_hi",   {32'd0, hi_o},     64'd0);
    chk("rst_lo",   {32'd0, lo_o},     64'd0);
    chk("rst_mcnd", {32'd0, mcnd_o},   64'd0);

    // Warm-up: a start on the first cycle after release is dropped
    @(posedge clk);
    #1;
    rst     = 1'b0;
    op_a_i  = 32'd3;
    op_b_i  = 32'd5;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("warm1_busy", {63'd0, busy_o},   64'd1);
    chk("warm1_en",   {63'd0, en_mul_o}, 64'd0);
    step();
    chk("warm2_busy", {63'd0, busy_o},   64'd1);
    chk("warm2_en",   {63'd0, en_mul_o}, 64'd0);
    step();
    chk("warm3_busy", {63'd0, busy_o},   64'd0);
    chk("warm3_en",   {63'd0, en_mul_o}, 64'd0);
    step();
    chk("warm_noq_en",   {63'd0, en_mul_o}, 64'd0);
    chk("warm_noq_mcnd", {32'd0, mcnd_o},   64'd0);

    // Table of multiplies; vector 3 is started in the DONE cycle of vector 2
    for (int i = 0; i < 6; i++) begin
      do_mul(vecs[i].a, vecs[i].b, en_cnt, done_k);
      chk($sformatf("v%0d_hi", i),     {32'd0, hi_o}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_lo", i),     {32'd0, lo_o}, {32'd0, vecs[i].lo});
      chk($sformatf("v%0d_en_cyc", i), 64'(en_cnt), 64'd34);
      chk($sformatf("v%0d_done_edge", i), 64'(done_k), 64'd34);
      chk($sformatf("v%0d_busy_done", i), {63'd0, busy_o}, 64'd0);
      chk($sformatf("v%0d_mcnd", i), {32'd0, mcnd_o}, {32'd0, vecs[i].a});
      chk($sformatf("v%0d_mplr", i), {32'd0, mplr_o}, {32'd0, vecs[i].b});
      mflo_i = 1'b1;
      #1;
      chk($sformatf("v%0d_mflo", i), {32'd0, rdata_o}, {32'd0, vecs[i].lo});
      mfhi_i = 1'b1;
      #1;
      chk($sformatf("v%0d_mfhi_mflo", i), {32'd0, rdata_o}, {32'd0, vecs[i].hi});
      mfhi_i = 1'b0;
      mflo_i = 1'b0;
      if (i == 2) begin
        chk("b2b_gap_en", {63'd0, en_mul_o}, 64'd0);
      end else begin
        step();
        chk($sformatf("v%0d_done_clr", i), {63'd0, done_o}, 64'd0);
      end
    end

    // MTHI / MTLO in IDLE
    mthi_i  = 1'b1;
    wdata_i = 32'hDEADBEEF;
    step();
    mthi_i = 1'b0;
    chk("mthi_hi", {32'd0, hi_o}, 64'h00000000DEADBEEF);
    #1;
    chk("rd_none", {32'd0, rdata_o}, 64'd0);
    mthi_i  = 1'b1;
    mtlo_i  = 1'b1;
    wdata_i = 32'h5A5A5A5A;
    step();
    mthi_i = 1'b0;
    mtlo_i = 1'b0;
    chk("mthilo_hi", {32'd0, hi_o}, 64'h000000005A5A5A5A);
    chk("mthilo_lo", {32'd0, lo_o}, 64'h000000005A5A5A5A);

    // MTHI together with start: HI takes wdata now, product later
    op_a_i  = 32'd7;
    op_b_i  = 32'd6;
    start_i = 1'b1;
    mthi_i  = 1'b1;
    wdata_i = 32'h0000AAAA;
    step();
    start_i = 1'b0;
    mthi_i  = 1'b0;
    chk("mthi_start_hi", {32'd0, hi_o}, 64'h000000000000AAAA);
    chk("mthi_start_en", {63'd0, en_mul_o}, 64'd1);
    done_k = -1;
    for (int k = 0; k < 100; k++) begin
      if (done_o) begin
        done_k = k;
        break;
      end
      step();
    end
    chk("mthi_start_done", 64'(done_k), 64'd34);
    chk("mthi_start_hi2", {32'd0, hi_o}, 64'd0);
    chk("mthi_start_lo2", {32'd0, lo_o}, 64'h000000000000002A);
    step();

    // MTLO and start during RUN are ignored; reset at cycle 10 of RUN
    lo_before = lo_o;
    op_a_i  = 32'd9;
    op_b_i  = 32'd9;
    start_i = 1'b1;
    step();
    op_a_i  = 32'd77;
    mtlo_i  = 1'b1;
    wdata_i = 32'h12345678;
    for (int k = 0; k < 3; k++) step();
    start_i = 1'b0;
    mtlo_i  = 1'b0;
    chk("run_mtlo_lo",   {32'd0, lo_o},     {32'd0, lo_before});
    chk("run_start_ign", {32'd0, mcnd_o},   64'd9);
    chk("run_en",        {63'd0, en_mul_o}, 64'd1);
    chk("run_busy",      {63'd0, busy_o},   64'd1);
    for (int k = 0; k < 7; k++) step();
    rst = 1'b1;
    #1;
    chk("abort_en",   {63'd0, en_mul_o}, 64'd0);
    chk("abort_hi",   {32'd0, hi_o},     64'd0);
    chk("abort_lo",   {32'd0, lo_o},     64'd0);
    chk("abort_busy", {63'd0, busy_o},   64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    step();
    chk("rewarm_busy2", {63'd0, busy_o}, 64'd1);
    step();
    chk("rewarm_busy3", {63'd0, busy_o}, 64'd0);
    do_mul(32'd2, 32'd2, en_cnt, done_k);
    chk("post_rst_lo",   {32'd0, lo_o}, 64'd4);
    chk("post_rst_hi",   {32'd0, hi_o}, 64'd0);
    chk("post_rst_done", 64'(done_k), 64'd34);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
